// File: rtl/vga_timing_ctrl_pkg.sv
// vga_timing_ctrl_pkg: shared VGA timing defaults, frame size and colour constants
// for the timing controller and the page renderers.
package vga_timing_ctrl_pkg;

    localparam int H_SYNC_DEF  = 96;
    localparam int H_BACK_DEF  = 40;
    localparam int H_LEFT_DEF  = 8;
    localparam int H_VALID_DEF = 640;
    localparam int H_TOTAL_DEF = 800;
    localparam int V_SYNC_DEF  = 2;
    localparam int V_BACK_DEF  = 25;
    localparam int V_TOP_DEF   = 8;
    localparam int V_VALID_DEF = 480;
    localparam int V_TOTAL_DEF = 525;

    localparam int VGA_WIDTH  = 640;
    localparam int VGA_HEIGHT = 480;

    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] BLACK = 16'h0000;

    function automatic logic in_range(input logic [9:0] val, input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA h/v counters with sync, pixel request and rgb gating.
// Define VGA_BORDER_EN to force a white frame on the outer active pixels.
module vga_timing_ctrl
    import vga_timing_ctrl_pkg::*;
#(
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BACK  = H_BACK_DEF,
    parameter int H_LEFT  = H_LEFT_DEF,
    parameter int H_VALID = H_VALID_DEF,
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BACK  = V_BACK_DEF,
    parameter int V_TOP   = V_TOP_DEF,
    parameter int V_VALID = V_VALID_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        frame_start
);

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC - 1);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC - 1);
    localparam logic [9:0] HA         = 10'(H_SYNC + H_BACK + H_LEFT);
    localparam logic [9:0] HA_END     = 10'(H_SYNC + H_BACK + H_LEFT + H_VALID - 1);
    localparam logic [9:0] VA         = 10'(V_SYNC + V_BACK + V_TOP);
    localparam logic [9:0] VA_END     = 10'(V_SYNC + V_BACK + V_TOP + V_VALID - 1);
    // Requests lead the active region by one pixel to cover the renderer's latency.
    localparam logic [9:0] REQ_START  = 10'(H_SYNC + H_BACK + H_LEFT - 1);
    localparam logic [9:0] REQ_END    = 10'(H_SYNC + H_BACK + H_LEFT + H_VALID - 2);

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       h_last;
    logic       active;
    logic       req;

    assign h_last = (cnt_h == H_LAST);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else begin
            cnt_h <= h_last ? '0 : cnt_h + 10'd1;
            if (h_last)
                cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 10'd1;
        end
    end

    assign active      = in_range(cnt_h, HA, HA_END) && in_range(cnt_v, VA, VA_END);
    assign req         = in_range(cnt_h, REQ_START, REQ_END) && in_range(cnt_v, VA, VA_END);
    assign hsync       = (cnt_h <= H_SYNC_END);
    assign vsync       = (cnt_v <= V_SYNC_END);
    assign frame_start = (cnt_h == '0) && (cnt_v == '0);
    assign pix_x       = req ? cnt_h - REQ_START : 10'h3FF;
    assign pix_y       = req ? cnt_v - VA : 10'h3FF;

`ifdef VGA_BORDER_EN
    logic border;
    assign border = (cnt_h == HA) || (cnt_h == HA_END) || (cnt_v == VA) || (cnt_v == VA_END);
    assign rgb    = !active ? BLACK : border ? WHITE : pix_data;
`else
    assign rgb    = active ? pix_data : BLACK;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: random pixel data against a cycle-count reference model
// on a reduced raster; includes a mid-frame asynchronous reset.
module tb_vga_timing_ctrl;

    localparam int HS = 4, HB = 3, HL = 1, HV = 16, HT = 30;
    localparam int VS = 2, VB = 2, VT_ = 1, VV = 8, VTOT = 16;
    localparam int HA = HS + HB + HL;
    localparam int VA = VS + VB + VT_;
    localparam int FT = HT * VTOT;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic [15:0] pix_data;
    logic [9:0]  pix_x, pix_y;
    logic        hsync, vsync, frame_start;
    logic [15:0] rgb;

    int checks = 0;
    int failures = 0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_LEFT(HL), .H_VALID(HV), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_TOP(VT_), .V_VALID(VV), .V_TOTAL(VTOT)
    ) dut (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .frame_start(frame_start)
    );

    task automatic chk(input string tag, input int t, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // Expected outputs depend only on cycles elapsed since reset release.
    task automatic check_at(input int t, input bit in_rst);
        int h, v;
        bit act, rq, brd;
        logic [15:0] exp_rgb;
        h = in_rst ? 0 : t % HT;
        v = in_rst ? 0 : (t / HT) % VTOT;
        act = (h >= HA) && (h < HA + HV) && (v >= VA) && (v < VA + VV);
        rq  = (h >= HA - 1) && (h < HA + HV - 1) && (v >= VA) && (v < VA + VV);
        brd = (h == HA) || (h == HA + HV - 1) || (v == VA) || (v == VA + VV - 1);
`ifdef VGA_BORDER_EN
        exp_rgb = !act ? 16'h0000 : brd ? 16'hFFFF : pix_data;
`else
        exp_rgb = act ? pix_data : 16'h0000;
        brd = 1'b0;
`endif
        chk("hsync", t, 16'(hsync), 16'(h < HS));
        chk("vsync", t, 16'(vsync), 16'(v < VS));
        chk("frame_start", t, 16'(frame_start), 16'(h == 0 && v == 0));
        chk("pix_x", t, 16'(pix_x), rq ? 16'(h - (HA - 1)) : 16'h03FF);
        chk("pix_y", t, 16'(pix_y), rq ? 16'(v - VA) : 16'h03FF);
        chk("rgb", t, rgb, exp_rgb);
    endtask

    task automatic run(input int n);
        for (int k = 1; k <= n; k++) begin
            @(posedge vga_clk);
            #1 pix_data = 16'($urandom);
            #1 check_at(k, 1'b0);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        pix_data  = 16'h5746;
        #12 check_at(0, 1'b1);
        sys_rst_n = 1'b1;
        #1 check_at(0, 1'b0);
        run(2 * FT + 7 * HT + 13);
        @(posedge vga_clk);
        #3 sys_rst_n = 1'b0;
        pix_data = 16'($urandom);
        #1 check_at(0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge vga_clk);
            #1 pix_data = 16'($urandom);
            #1 check_at(0, 1'b1);
        end
        @(posedge vga_clk);
        #3 sys_rst_n = 1'b1;
        #1 check_at(0, 1'b0);
        run(FT + 5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
